// File: rtl/axis_uart_rx_packer.sv
// rtl/axis_uart_rx_packer.sv - packs UART receive characters into little-endian AXI-Stream words
module axis_uart_rx_packer #(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int DATA_BITS      = 8,
    parameter int TIMEOUT_CYCLES = 34_720
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [AXI_DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    input  logic                        flush,
    output logic [AXI_DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [AXI_DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                        m_axis_tlast,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready
);

    localparam int LANES = AXI_DATA_WIDTH / 8;
    localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LANES - 1);
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic {FILL, HOLD} state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [TMR_W-1:0]          tmr_q, tmr_d;
    logic [AXI_DATA_WIDTH-1:0] data_q, data_d;
    logic [LANES-1:0]          keep_q, keep_d;
    logic                      last_q, last_d;
    logic                      ready_q;
    logic [7:0]                ch;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= FILL;
            cnt_q   <= '0;
            tmr_q   <= '0;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmr_q   <= tmr_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
            last_q  <= last_d;
            ready_q <= (state_d == FILL);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tmr_d   = tmr_q;
        data_d  = data_q;
        keep_d  = keep_q;
        last_d  = last_q;
        ch      = '0;
        ch[DATA_BITS-1:0] = s_axis_tdata[DATA_BITS-1:0];
        case (state_q)
            FILL: begin
                if (s_axis_tvalid && ready_q) begin
                    // An accepted character always restarts the idle timer, even on the expiry cycle
                    for (int i = 0; i < LANES; i++) begin
                        if (cnt_q == CNT_W'(i)) begin
                            data_d[i*8 +: 8] = ch;
                            keep_d[i]        = 1'b1;
                        end
                    end
                    tmr_d = '0;
                    if (cnt_q == CNT_MAX) begin
                        state_d = HOLD;
                        last_d  = flush;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (flush) begin
                            state_d = HOLD;
                            last_d  = 1'b1;
                        end
                    end
                end else if (cnt_q != '0) begin
                    if (flush || tmr_q == TMR_MAX) begin
                        state_d = HOLD;
                        last_d  = 1'b1;
                    end else begin
                        tmr_d = tmr_q + TMR_W'(1);
                    end
                end else begin
                    tmr_d = '0;
                end
            end
            HOLD: begin
                if (m_axis_tready) begin
                    state_d = FILL;
                    cnt_d   = '0;
                    tmr_d   = '0;
                    data_d  = '0;
                    keep_d  = '0;
                    last_d  = 1'b0;
                end
            end
            default: state_d = FILL;
        endcase
    end

    assign s_axis_tready = ready_q;
    assign m_axis_tvalid = (state_q == HOLD);
    assign m_axis_tdata  = data_q;
    assign m_axis_tkeep  = keep_q;
    assign m_axis_tlast  = last_q;

endmodule

// File: doc/axis_uart_rx_packer.md
# axis_uart_rx_packer

Packs the byte stream produced by the UART transceiver's receive AXI-Stream master into full-width AXI-Stream words for the downstream system bus. It sits directly after the transceiver's `m_axis` port. A partial word is emitted with `tlast` on a line-idle timeout or an explicit flush, so short messages never stall inside the packer. Little-endian lane order: the first received character goes in lane 0.

## Interface
Parameters:
- `AXI_DATA_WIDTH`, 32: width of both streams; must be a multiple of 8. LANES = AXI_DATA_WIDTH/8.
- `DATA_BITS`, 8: valid character bits in `s_axis_tdata[DATA_BITS-1:0]`; must be ≤ 8.
- `TIMEOUT_CYCLES`, 34_720: idle cycles after the last accepted character before a partial word is flushed (4 characters at 115200 baud, 100 MHz); must be ≥ 2.

Ports:
- `aclk`  in  1  single clock.
- `aresetn`  in  1  asynchronous, active-low reset.
- `s_axis_tdata`  in  AXI_DATA_WIDTH  received character in bits [DATA_BITS-1:0]; the remaining bits are ignored.
- `s_axis_tvalid`  in  1  character valid.
- `s_axis_tready`  out  1  packer can accept a character.
- `flush`  in  1  single-cycle request to emit the current partial word with `tlast`.
- `m_axis_tdata`  out  AXI_DATA_WIDTH  packed word; unfilled lanes are zero.
- `m_axis_tkeep`  out  LANES  lane-valid mask; contiguous from bit 0.
- `m_axis_tlast`  out  1  word was closed by a timeout or flush.
- `m_axis_tvalid`  out  1  word valid.
- `m_axis_tready`  in  1  downstream accepts the word.

## Operation
- Two states:
  - FILL: `s_axis_tready`=1 and `m_axis_tvalid`=0.
  - HOLD: `s_axis_tready`=0 and `m_axis_tvalid`=1.
- Internal registers:
  - lane counter `cnt` (0..LANES-1)
  - data/keep accumulators
  - idle timer of width clog2(TIMEOUT_CYCLES+1)
- FILL, character accepted (`s_axis_tvalid`&&`s_axis_tready`):
  - Write zero-extended `s_axis_tdata[DATA_BITS-1:0]` into lane `cnt`.
  - Set `keep[cnt]`.
  - Clear the idle timer.
  - If `cnt`==LANES-1: go to HOLD with `tkeep` all ones and `tlast`=`flush`. Otherwise `cnt`++.
- FILL, no character, `cnt`>0:
  - The idle timer increments.
  - When the timer reaches TIMEOUT_CYCLES-1, or `flush`=1, go to HOLD with the current keep and `tlast`=1.
- FILL, `cnt`==0: the timer is held at 0, and `flush` is ignored (no empty words are ever emitted).
- Simultaneous character acceptance and timeout expiry: the character is stored and the timer restarts. Acceptance wins.
- Simultaneous character acceptance and `flush`: the character is included, then the word is closed with `tlast`=1.
- HOLD:
  - Outputs are stable until `m_axis_tready`=1.
  - On handshake, return to FILL; `cnt`, timer, data and keep are cleared.
  - `flush` in HOLD is ignored.
  - Characters are back-pressured. The transceiver holds at most one pending character, so the next word begins with it.
- Reset (`aresetn`=0, asynchronous):
  - State goes to FILL; all accumulators and the timer clear.
  - `s_axis_tready`=0, `m_axis_tvalid`=0, `m_axis_tdata`=0, `m_axis_tkeep`=0, `m_axis_tlast`=0.
  - A partial word present at reset is discarded.

## Timing
- All outputs are registered; there is no combinational path from any input to any output.
- `s_axis_tready` rises on the first `aclk` edge after `aresetn` deasserts.
- Latency:
  - From acceptance of the completing character to `m_axis_tvalid`=1: 1 cycle.
  - From the last character to timeout `m_axis_tvalid`: TIMEOUT_CYCLES cycles.
  - From `flush` to `m_axis_tvalid`: 1 cycle.
- After the output handshake, `s_axis_tready`=1 on the next cycle. Minimum spacing between words is therefore LANES+1 cycles; UART character rate is far below this.
- AXI-Stream rule: once `m_axis_tvalid` is asserted, `tdata`/`tkeep`/`tlast` must not change until the handshake.

## Test plan
- Send 0x11,0x22,0x33,0x44 back-to-back, `m_axis_tready`=1 → one word: tdata 0x44332211, tkeep 0xF, tlast 0, valid exactly 1 cycle after the 4th accept.
- Send 0xA5,0x5A, then idle (TIMEOUT_CYCLES=16) → tdata 0x00005AA5, tkeep 0x3, tlast 1, valid 16 cycles after the 2nd accept.
- Send 0x01 with `flush` pulsed in the same cycle → tdata 0x00000001, tkeep 0x1, tlast 1; `flush` with `cnt`==0 → no output.
- Hold `m_axis_tready`=0 for 20 cycles after a full word, presenting 0x55 → `s_axis_tready`=0 and tdata stable throughout; after the handshake 0x55 lands in lane 0 of the next word.
- Send 0x77 at exactly the timeout-expiry cycle after 0x66 → no flush; the next word contains 0x66 in lane 0 and 0x77 in lane 1.
- Assert `aresetn`=0 mid-word (cnt=2) and in HOLD → all outputs 0 immediately. After release, the next 4 characters form a clean word with no residue.
